// File: rtl/api_sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full threshold and sticky error flags.
// Optional first-word-fall-through output stage enabled by defining API_FIFO_FWFT_EN.
module api_sync_fifo #(
    parameter int DW        = 32,
    parameter int AW        = 10,
    parameter int AFULL_THR = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          srst,
    input  logic [DW-1:0] din,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic [AW:0]   data_count,
    output logic          overflow,
    output logic          underflow
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   DEPTH_C   = DEPTH[AW:0];
    localparam logic [AW:0]   AFULL_C   = AFULL_THR[AW:0];
    localparam logic [AW:0]   CNT_ONE_C = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE_C = {{(AW-1){1'b0}}, 1'b1};

    logic [DW-1:0] ram_r [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          rd_ok_s, wr_ok_s, ram_we_s;
`ifdef API_FIFO_FWFT_EN
    logic          ov_q, ov_d;
    logic [AW:0]   ram_cnt_s;
`endif

    // Next-state computation: accept rules, pointers, count, flags and read data
    always_comb begin
        rd_ok_s  = rd_en & ~empty_q;
        wr_ok_s  = wr_en & (~full_q | rd_ok_s);
        ram_we_s = wr_ok_s & ~srst;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        full_d   = full_q;
        empty_d  = empty_q;
        afull_d  = afull_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
`ifdef API_FIFO_FWFT_EN
        ov_d      = ov_q;
        ram_cnt_s = count_q - {{AW{1'b0}}, ov_q};
`endif
        if (srst) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {(AW+1){1'b0}};
            dout_d   = {DW{1'b0}};
            full_d   = 1'b0;
            empty_d  = 1'b1;
            afull_d  = 1'b0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
`ifdef API_FIFO_FWFT_EN
            ov_d     = 1'b0;
`endif
        end else begin
            if (wr_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE_C;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_d = count_q + CNT_ONE_C;
                2'b01:   count_d = count_q - CNT_ONE_C;
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (wr_en & ~wr_ok_s);
            udf_d = udf_q | (rd_en & ~rd_ok_s);
`ifdef API_FIFO_FWFT_EN
            // Refill the output register whenever it is free or being consumed;
            // the word being written this cycle is not yet visible in ram_cnt_s.
            if ((ram_cnt_s != {(AW+1){1'b0}}) && (~ov_q || rd_ok_s)) begin
                dout_d   = ram_r[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + PTR_ONE_C;
                ov_d     = 1'b1;
            end else if (rd_ok_s) begin
                ov_d     = 1'b0;
            end else begin
                ov_d     = ov_q;
            end
            empty_d = ~ov_d;
`else
            if (rd_ok_s) begin
                dout_d   = ram_r[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + PTR_ONE_C;
            end else begin
                dout_d   = dout_q;
                rd_ptr_d = rd_ptr_q;
            end
            empty_d = (count_d == {(AW+1){1'b0}});
`endif
            full_d  = (count_d == DEPTH_C);
            afull_d = (count_d >= AFULL_C);
        end
    end

    // Storage array: write-only port, no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[wr_ptr_q] <= din;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
            dout_q   <= {DW{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
`ifdef API_FIFO_FWFT_EN
            ov_q     <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
`ifdef API_FIFO_FWFT_EN
            ov_q     <= ov_d;
`endif
        end
    end

    assign dout        = dout_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = afull_q;
    assign data_count  = count_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

endmodule
